// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for a 1R/1W block RAM with a parked write port.
// Define MEM_PORT_ARBITER_CLEAR_EN to zero the RAM with a sweep after every reset.
module mem_port_arbiter #(
  parameter int WID_MEM = 17,
  parameter int DEPTH_MEM = 4096,
  parameter int AW = 12,
  parameter logic [AW-1:0] PARK_ADDR = AW'(DEPTH_MEM - 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               a_req,
  input  logic               a_we,
  input  logic [AW-1:0]      a_addr,
  input  logic [WID_MEM-1:0] a_wdata,
  output logic               a_gnt,
  output logic               a_rvalid,
  output logic [WID_MEM-1:0] a_rdata,
  input  logic               b_req,
  input  logic               b_we,
  input  logic [AW-1:0]      b_addr,
  input  logic [WID_MEM-1:0] b_wdata,
  output logic               b_gnt,
  output logic               b_rvalid,
  output logic [WID_MEM-1:0] b_rdata,
  output logic [AW-1:0]      mem_raddr,
  output logic [AW-1:0]      mem_waddr,
  output logic [WID_MEM-1:0] mem_din,
  input  logic [WID_MEM-1:0] mem_dout,
  output logic               busy
);

  logic          run;
  logic          sweeping;
  logic [AW-1:0] clr_addr;

`ifdef MEM_PORT_ARBITER_CLEAR_EN
  typedef enum logic {CLEAR, RUN} state_t;
  state_t        state, state_nxt;
  logic [AW-1:0] sweep_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR;
      sweep_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) sweep_addr <= sweep_addr + AW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && sweep_addr == AW'(DEPTH_MEM - 1)) state_nxt = RUN;
  end

  assign run      = ~reset && (state == RUN);
  assign sweeping = ~reset && (state == CLEAR);
  assign clr_addr = sweep_addr;
  assign busy     = (state == CLEAR);
`else
  assign run      = ~reset;
  assign sweeping = 1'b0;
  assign clr_addr = '0;
  assign busy     = 1'b0;
`endif

  logic a_rd, b_rd, a_wr, b_wr;
  logic a_rgnt, b_rgnt, a_wgnt, b_wgnt;
  logic ptr_r, ptr_w, ptr_r_nxt, ptr_w_nxt;
  logic [AW-1:0] raddr_q;

  assign a_rd = run & a_req & ~a_we;
  assign b_rd = run & b_req & ~b_we;
  assign a_wr = run & a_req &  a_we;
  assign b_wr = run & b_req &  b_we;

  // Pointer 0 favours A; it flips only when both requesters contend for the port.
  always_comb begin
    a_rgnt    = a_rd & (~b_rd | ~ptr_r);
    b_rgnt    = b_rd & (~a_rd |  ptr_r);
    a_wgnt    = a_wr & (~b_wr | ~ptr_w);
    b_wgnt    = b_wr & (~a_wr |  ptr_w);
    ptr_r_nxt = ptr_r;
    ptr_w_nxt = ptr_w;
    if (a_rd && b_rd) ptr_r_nxt = ~ptr_r;
    if (a_wr && b_wr) ptr_w_nxt = ~ptr_w;
  end

  assign a_gnt = a_rgnt | a_wgnt;
  assign b_gnt = b_rgnt | b_wgnt;

  always_comb begin
    mem_raddr = raddr_q;
    if (a_rgnt)      mem_raddr = a_addr;
    else if (b_rgnt) mem_raddr = b_addr;
  end

  always_comb begin
    mem_waddr = PARK_ADDR;
    mem_din   = '0;
    if (sweeping) begin
      mem_waddr = clr_addr;
    end else if (a_wgnt) begin
      mem_waddr = a_addr;
      mem_din   = a_wdata;
    end else if (b_wgnt) begin
      mem_waddr = b_addr;
      mem_din   = b_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r    <= 1'b0;
      ptr_w    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      raddr_q  <= '0;
    end else begin
      ptr_r    <= ptr_r_nxt;
      ptr_w    <= ptr_w_nxt;
      a_rvalid <= a_rgnt;
      b_rvalid <= b_rgnt;
      raddr_q  <= mem_raddr;
    end
  end

  assign a_rdata = mem_dout;
  assign b_rdata = mem_dout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed table-driven bench for mem_port_arbiter with a read-first RAM model.
// Also covers the clear sweep when MEM_PORT_ARBITER_CLEAR_EN is defined.
module tb_mem_port_arbiter;

  localparam logic [11:0] P = 12'hFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [11:0] a_addr, b_addr;
  logic [16:0] a_wdata, b_wdata;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid, busy;
  logic [16:0] a_rdata, b_rdata, mem_din, mem_dout;
  logic [11:0] mem_raddr, mem_waddr;

  int tests = 0;
  int fails = 0;

  mem_port_arbiter #(.WID_MEM(17), .DEPTH_MEM(4096), .AW(12)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [16:0] ram [4096];
  initial for (int i = 0; i < 4096; i++) ram[i] = 17'(i * 3 + 1);
  always @(posedge clk) begin
    mem_dout <= ram[mem_raddr];
    ram[mem_waddr] <= mem_din;
  end

  function automatic logic [16:0] iv(input int i);
`ifdef MEM_PORT_ARBITER_CLEAR_EN
    return 17'(0 * i);
`else
    return 17'(i * 3 + 1);
`endif
  endfunction

  typedef struct {
    logic ar, aw; logic [11:0] aa; logic [16:0] ad;
    logic br, bw; logic [11:0] ba; logic [16:0] bd;
    logic eag, ebg; logic [11:0] era, ewa; logic [16:0] ed;
    logic eav, ebv; logic [16:0] erd;
  } vec_t;

  function automatic vec_t mk(input logic ar, aw, input logic [11:0] aa, input logic [16:0] ad,
                              input logic br, bw, input logic [11:0] ba, input logic [16:0] bd,
                              input logic eag, ebg, input logic [11:0] era, ewa,
                              input logic [16:0] ed, input logic eav, ebv, input logic [16:0] erd);
    vec_t v;
    v.ar = ar; v.aw = aw; v.aa = aa; v.ad = ad;
    v.br = br; v.bw = bw; v.ba = ba; v.bd = bd;
    v.eag = eag; v.ebg = ebg; v.era = era; v.ewa = ewa; v.ed = ed;
    v.eav = eav; v.ebv = ebv; v.erd = erd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ar, aw, input logic [11:0] aa, input logic [16:0] ad,
                       input logic br, bw, input logic [11:0] ba, input logic [16:0] bd);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
  endtask

  task automatic wait_run();
    int n = 0;
    while (busy === 1'b1 && n < 5000) begin
      @(negedge clk); #1; n++;
    end
    chk("wait_run busy", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  vec_t vecs[30];
  logic [11:0] raddr0;

  initial begin
`ifdef MEM_PORT_ARBITER_CLEAR_EN
    raddr0 = 12'd9;
`else
    raddr0 = 12'd0;
`endif
    vecs[0]  = mk(1,1,5,17'h1ABCD, 0,0,0,0, 1,0, raddr0, 5,17'h1ABCD, 0,0,0);
    vecs[1]  = mk(1,0,5,0, 0,0,0,0, 1,0, 5,P,0, 1,0,17'h1ABCD);
    vecs[2]  = mk(1,0,3,0, 1,0,4,0, 1,0, 3,P,0, 1,0,iv(3));
    vecs[3]  = mk(1,0,3,0, 1,0,4,0, 0,1, 4,P,0, 0,1,iv(4));
    vecs[4]  = mk(1,0,3,0, 1,0,4,0, 1,0, 3,P,0, 1,0,iv(3));
    vecs[5]  = mk(1,0,3,0, 1,0,4,0, 0,1, 4,P,0, 0,1,iv(4));
    vecs[6]  = mk(1,0,7,0, 1,1,7,1, 1,1, 7,7,1, 1,0,iv(7));
    vecs[7]  = mk(1,0,7,0, 0,0,0,0, 1,0, 7,P,0, 1,0,1);
    vecs[8]  = mk(1,1,0,17'h155, 0,0,0,0, 1,0, 7,0,17'h155, 0,0,0);
    for (int i = 9; i < 19; i++) vecs[i] = mk(0,0,0,0, 0,0,0,0, 0,0, 7,P,0, 0,0,0);
    vecs[19] = mk(1,0,0,0, 0,0,0,0, 1,0, 0,P,0, 1,0,17'h155);
    vecs[20] = mk(1,1,10,17'h11, 1,1,11,17'h22, 1,0, 0,10,17'h11, 0,0,0);
    vecs[21] = mk(0,0,0,0, 1,1,11,17'h22, 0,1, 0,11,17'h22, 0,0,0);
    vecs[22] = mk(1,1,12,17'h33, 1,1,13,17'h44, 0,1, 0,13,17'h44, 0,0,0);
    vecs[23] = mk(1,1,12,17'h33, 0,0,0,0, 1,0, 0,12,17'h33, 0,0,0);
    vecs[24] = mk(1,0,10,0, 0,0,0,0, 1,0, 10,P,0, 1,0,17'h11);
    vecs[25] = mk(0,0,0,0, 1,0,11,0, 0,1, 11,P,0, 0,1,17'h22);
    vecs[26] = mk(0,0,0,0, 1,0,13,0, 0,1, 13,P,0, 0,1,17'h44);
    vecs[27] = mk(1,0,12,0, 0,0,0,0, 1,0, 12,P,0, 1,0,17'h33);
    vecs[28] = mk(1,0,1,0, 1,0,2,0, 1,0, 1,P,0, 1,0,iv(1));
    vecs[29] = mk(1,1,20,7, 1,0,5,0, 1,1, 5,20,7, 0,1,17'h1ABCD);

    // Reset with requests asserted: nothing may be granted.
    reset = 1'b1;
    drive(1,0,3,0, 1,1,4,5);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst a_gnt", a_gnt, 0);
    chk("rst b_gnt", b_gnt, 0);
    chk("rst mem_waddr", mem_waddr, P);
    chk("rst mem_din", mem_din, 0);
    chk("rst mem_raddr", mem_raddr, 0);
    chk("rst a_rvalid", a_rvalid, 0);
    chk("rst b_rvalid", b_rvalid, 0);
`ifdef MEM_PORT_ARBITER_CLEAR_EN
    chk("rst busy", busy, 1);
`else
    chk("rst busy", busy, 0);
`endif
    drive(0,0,0,0, 0,0,0,0);

`ifdef MEM_PORT_ARBITER_CLEAR_EN
    begin
      int bad = 0;
      int n = 0;
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 100; c++) begin
        #1;
        if (busy !== 1'b1 || mem_waddr !== 12'(c)) bad++;
        @(negedge clk);
      end
      chk("sweep prefix", bad, 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      drive(1,0,9,0, 0,0,0,0);
      bad = 0;
      for (int c = 1; c <= 5000; c++) begin
        #1;
        if (a_gnt === 1'b1) begin n = c; break; end
        if (busy !== 1'b1 || mem_waddr !== 12'(c - 1)) bad++;
        @(negedge clk);
      end
      chk("sweep grant cycle", n, 4097);
      chk("sweep restart sequence", bad, 0);
      chk("sweep busy at grant", busy, 0);
      @(posedge clk); #1;
      chk("sweep a_rvalid", a_rvalid, 1);
      chk("sweep a_rdata", a_rdata, 0);
    end
`endif

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      reset = 1'b0;
      drive(vecs[i].ar, vecs[i].aw, vecs[i].aa, vecs[i].ad,
            vecs[i].br, vecs[i].bw, vecs[i].ba, vecs[i].bd);
      #1;
      chk($sformatf("v%0d a_gnt", i), a_gnt, vecs[i].eag);
      chk($sformatf("v%0d b_gnt", i), b_gnt, vecs[i].ebg);
      chk($sformatf("v%0d mem_raddr", i), mem_raddr, vecs[i].era);
      chk($sformatf("v%0d mem_waddr", i), mem_waddr, vecs[i].ewa);
      chk($sformatf("v%0d mem_din", i), mem_din, vecs[i].ed);
      @(posedge clk); #1;
      chk($sformatf("v%0d a_rvalid", i), a_rvalid, vecs[i].eav);
      chk($sformatf("v%0d b_rvalid", i), b_rvalid, vecs[i].ebv);
      if (vecs[i].eav) chk($sformatf("v%0d a_rdata", i), a_rdata, vecs[i].erd);
      if (vecs[i].ebv) chk($sformatf("v%0d b_rdata", i), b_rdata, vecs[i].erd);
    end

    // Skew both pointers away from A, then reset and confirm they favour A again.
    @(negedge clk);
    drive(1,1,30,5, 1,1,31,6); #1;
    chk("h1 a_gnt", a_gnt, 1);
    chk("h1 b_gnt", b_gnt, 0);
    @(negedge clk);
    drive(1,0,1,0, 1,0,2,0); #1;
    chk("h2 b_gnt", b_gnt, 1);
    chk("h2 a_gnt", a_gnt, 0);
    @(negedge clk); #1;
    chk("h3 a_gnt", a_gnt, 1);
    chk("h3 b_gnt", b_gnt, 0);
    @(negedge clk);
    reset = 1'b1; #1;
    chk("h4 a_gnt in reset", a_gnt, 0);
    chk("h4 b_gnt in reset", b_gnt, 0);
    chk("h4 mem_waddr in reset", mem_waddr, P);
    @(posedge clk); #1;
    chk("h4 a_rvalid cancelled", a_rvalid, 0);
    chk("h4 b_rvalid cancelled", b_rvalid, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(0,0,0,0, 0,0,0,0); #1;
    chk("h5 mem_raddr after reset", mem_raddr, 0);
    wait_run();
    @(negedge clk);
    drive(1,0,1,0, 1,0,2,0); #1;
    chk("h6 a_gnt ptr_r reset", a_gnt, 1);
    chk("h6 b_gnt ptr_r reset", b_gnt, 0);
    chk("h6 mem_raddr", mem_raddr, 1);
    @(posedge clk); #1;
    chk("h6 a_rvalid", a_rvalid, 1);
    chk("h6 b_rvalid", b_rvalid, 0);
    chk("h6 a_rdata", a_rdata, iv(1));
    @(negedge clk);
    drive(1,1,40,8, 1,1,41,9); #1;
    chk("h7 a_gnt ptr_w reset", a_gnt, 1);
    chk("h7 b_gnt ptr_w reset", b_gnt, 0);
    chk("h7 mem_waddr", mem_waddr, 40);
    chk("h7 mem_din", mem_din, 8);
    @(negedge clk);
    drive(0,0,0,0, 0,0,0,0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one read/write-port block RAM (default 17 bits × 4096) between two requesters, A and B. Independent round-robin arbiters serve the read port and the write port. The arbiter returns read data with a per-requester valid pulse. The RAM writes `din` to `waddr` on every clock with no write enable, so on idle cycles this block parks the write port on a reserved scratch address. It sits between the client logic and the memory instance in the top level.

## Interface
Parameters:
- `WID_MEM`, 17, data width
- `DEPTH_MEM`, 4096, word count
- `AW`, 12, address width; must satisfy 2^AW ≥ DEPTH_MEM
- `PARK_ADDR`, DEPTH_MEM-1, reserved scratch address; contents are undefined and clients must not use it

Ports:
- `clk` in 1: the single clock
- `reset` in 1: synchronous, active-high
- `a_req` in 1: A command request
- `a_we` in 1: 1 = write, 0 = read
- `a_addr` in AW: A address
- `a_wdata` in WID_MEM: A write data
- `a_gnt` out 1: A command accepted this cycle
- `a_rvalid` out 1: A read data valid
- `a_rdata` out WID_MEM: A read data
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_gnt`, `b_rvalid`, `b_rdata`: identical set for requester B
- `mem_raddr` out AW: to RAM read address
- `mem_waddr` out AW: to RAM write address
- `mem_din` out WID_MEM: to RAM write data
- `mem_dout` in WID_MEM: from RAM; registered read data
- `busy` out 1: clear sweep in progress (always 0 when the sweep is compiled out)

## Operation
Requester handshake:
- A requester holds `x_req`, `x_we`, `x_addr` and `x_wdata` stable until it sees `x_gnt`=1 in the same cycle.
- `x_gnt` is combinational from the request inputs.
- One command per requester per cycle.

Arbitration:
- Reads and writes are arbitrated separately.
- An A read and a B write (or the reverse) are both granted in the same cycle.
- When both requesters want the same port, the requester not granted last on that port wins. Each port has its own one-bit pointer.
- The pointer updates only on a contested grant. On reset both pointers favour A.

Port muxing:
- Read port: `mem_raddr` = granted read address. With no read grant it holds its previous value; the read result is ignored.
- Write port: `mem_waddr`/`mem_din` = granted write address and data.
- With no write grant: `mem_waddr`=PARK_ADDR and `mem_din`=0.

Read return:
- `x_rvalid` is registered, high exactly one cycle after `x`'s read grant.
- `x_rdata` = `mem_dout` passed through. It is meaningful only while `x_rvalid`=1.

Same-address read and write in one cycle:
- The read returns the old contents (read-first). The arbiter does not forward write data.

FSM states: CLEAR (only with the sweep compiled in) and RUN.
- In CLEAR, all grants are 0 and requests are ignored; requesters must keep holding them.

## Timing
Values during and directly after reset:
- `a_gnt`/`b_gnt`: 0
- `a_rvalid`/`b_rvalid`: 0
- `mem_waddr`: PARK_ADDR
- `mem_din`: 0
- `mem_raddr`: 0
- `busy`: 1 with the sweep compiled in, else 0
- Both arbiter pointers favour A.

Latency:
- Grant: 0 cycles.
- Read data: 1 cycle after grant.
- Write: committed at the clock edge ending the grant cycle.

Reset mid-operation:
- Pending `x_rvalid` is cancelled.
- Pointers return to favouring A.
- The sweep restarts from address 0.

Back-to-back:
- One requester may be granted on every cycle. Uncontested throughput is one read plus one write per cycle.

## Configuration
Macro `MEM_PORT_ARBITER_CLEAR_EN`.

Defined:
- After reset deasserts, the FSM is in CLEAR for DEPTH_MEM cycles.
- It writes 0 to addresses 0..DEPTH_MEM-1 in ascending order, one per cycle, through the write port. `busy`=1 throughout.
- It enters RUN on the cycle after address DEPTH_MEM-1 is written. `busy` falls in that same cycle.

Undefined:
- There is no CLEAR state. The FSM is in RUN on the first cycle after reset and `busy` is tied to 0.
- RAM keeps its file-initialised contents.

## Test plan
- A writes 0x1ABCD at addr 5; next cycle A reads addr 5 → `a_gnt`=1 both cycles; `a_rvalid`=1 one cycle after the read grant with `a_rdata`=0x1ABCD.
- A and B both request reads of addresses 3 and 4 for 4 consecutive cycles after reset → grants alternate A, B, A, B; each `x_rvalid` follows its grant by exactly one cycle; B never sees `rvalid` in a cycle following an A grant.
- A reads addr 7 while B writes 0x00001 to addr 7 in the same cycle → both granted; `a_rdata`=old value; a following A read of addr 7 returns 0x00001.
- Idle for 10 cycles after writing 0x155 at addr 0 → `mem_waddr`=PARK_ADDR and `mem_din`=0 every idle cycle; a read of addr 0 still returns 0x155.
- With `MEM_PORT_ARBITER_CLEAR_EN` defined, A holds a read request on addr 9 from the cycle after reset deasserts → `busy`=1 and `a_gnt`=0 for 4096 cycles; the grant occurs on cycle 4097; `a_rdata`=0.
- With `MEM_PORT_ARBITER_CLEAR_EN` defined, assert `reset` for one cycle partway through the sweep → `busy` remains 1 and the sweep restarts at address 0.
